// File: rtl/ctech_lib_clk_pkg.sv
// rtl/ctech_lib_clk_pkg.sv - shared types and limits for the gated clock branch sequencer
package ctech_lib_clk_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HYST = 2'd3
    } ctech_clk_gate_state_t;

    // wake_cnt is 4 bits wide, so the settle time cannot exceed this
    localparam int CTECH_CLK_WAKE_MAX = 15;

endpackage

// File: rtl/ctech_lib_clk_dncnt.sv
// rtl/ctech_lib_clk_dncnt.sv - loadable down counter that saturates at zero, with zero flag
module ctech_lib_clk_dncnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctech_lib_clk_gate_ctrl.sv
// rtl/ctech_lib_clk_gate_ctrl.sv - request/ack sequencer driving the enable of one gated clock branch
module ctech_lib_clk_gate_ctrl
    import ctech_lib_clk_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    input  logic               force_on,
    input  logic [HYST_W-1:0]  hyst_val,
    output logic               clken,
    output logic               clk_active
);

    if ((WAKE_CYC < 1) || (WAKE_CYC > CTECH_CLK_WAKE_MAX)) begin : g_bad_wake_cyc
        $error("ctech_lib_clk_gate_ctrl: WAKE_CYC must be in 1..15");
    end
    if ((NUM_REQ < 1) || (NUM_REQ > 16)) begin : g_bad_num_req
        $error("ctech_lib_clk_gate_ctrl: NUM_REQ must be in 1..16");
    end

    ctech_clk_gate_state_t state_q, state_d;
    logic                  clken_q, clken_d;
    logic                  clk_active_q, clk_active_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;

    logic any_req;
    logic wake_load, wake_dec, wake_zero;
    logic hyst_load, hyst_dec, hyst_zero;

    always_comb begin
        any_req   = (|req) | force_on;
        state_d   = state_q;
        wake_load = 1'b0;
        hyst_load = 1'b0;
        case (state_q)
            OFF: begin
                if (any_req) begin
                    state_d   = WAKE;
                    wake_load = 1'b1;
                end
            end
            // Settle time always runs to completion, even if requests vanish
            WAKE: begin
                if (wake_zero) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (!any_req) begin
                    if (hyst_val == '0) begin
                        state_d = OFF;
                    end else begin
                        state_d   = HYST;
                        hyst_load = 1'b1;
                    end
                end
            end
            // A new request wins over an expiring hysteresis count
            HYST: begin
                if (any_req) begin
                    state_d = ON;
                end else if (hyst_zero) begin
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase

        wake_dec     = (state_q == WAKE);
        hyst_dec     = (state_q == HYST) && !any_req;
        clken_d      = (state_d != OFF);
        clk_active_d = (state_d == ON);
        ack_d        = ((state_q == ON) && (state_d == ON)) ? req : '0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= OFF;
            clken_q      <= 1'b0;
            clk_active_q <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            clken_q      <= clken_d;
            clk_active_q <= clk_active_d;
            ack_q        <= ack_d;
        end
    end

    ctech_lib_clk_dncnt #(.W(4)) u_wake_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (wake_load),
        .load_val (4'(WAKE_CYC - 1)),
        .dec      (wake_dec),
        .zero     (wake_zero)
    );

    ctech_lib_clk_dncnt #(.W(HYST_W)) u_hyst_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (hyst_load),
        .load_val (hyst_val - HYST_W'(1)),
        .dec      (hyst_dec),
        .zero     (hyst_zero)
    );

    assign clken      = clken_q;
    assign clk_active = clk_active_q;
    assign ack        = ack_q;

endmodule
